pick_dir_ctrl: RTL and testbench



---
 rtl/pick_dir_ctrl.sv | 148 ++++++++++++++
 tb/tb_pick_dir_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pick_dir_ctrl.sv
// rtl/pick_dir_ctrl.sv - per-frame keyboard to pick direction controller with hold-to-accelerate and reversal brake
module pick_dir_ctrl #(
    parameter logic [7:0] KEY_UP    = 8'h1A,
    parameter logic [7:0] KEY_DOWN  = 8'h16,
    parameter int         FAST_HOLD = 30,
    parameter int         CNT_W     = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [2:0] dir,
    output logic       fast
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP_S  = 3'd1,
        UP_F  = 3'd2,
        DN_S  = 3'd3,
        DN_F  = 3'd4,
        BRAKE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(FAST_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [2:0] DIR_STOP   = 3'b000;
    localparam logic [2:0] DIR_UP_S   = 3'b001;
    localparam logic [2:0] DIR_DN_S   = 3'b010;
    localparam logic [2:0] DIR_DN_F   = 3'b011;
    localparam logic [2:0] DIR_UP_F   = 3'b100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       dir_q, dir_d;
    logic             fast_q, fast_d;

    logic up_req, dn_req, up_key, dn_key;

    // Key decode: both directions pressed together counts as no key at all
    always_comb begin
        up_req = (keycode0 == KEY_UP)   | (keycode1 == KEY_UP);
        dn_req = (keycode0 == KEY_DOWN) | (keycode1 == KEY_DOWN);
        up_key = up_req & ~dn_req;
        dn_key = dn_req & ~up_req;
    end

    // Next-state, hold counter and output decode; outputs follow the next state so they change on the same edge
    always_comb begin
        state_d    = IDLE;
        hold_cnt_d = CNT_ZERO;
        case (state_q)
            IDLE, BRAKE: begin
                // BRAKE behaves like IDLE on its way out, so it lasts exactly one frame
                if (up_key) begin
                    state_d    = UP_S;
                    hold_cnt_d = CNT_ONE;
                end else if (dn_key) begin
                    state_d    = DN_S;
                    hold_cnt_d = CNT_ONE;
                end
            end
            UP_S: begin
                if (up_key) begin
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d    = UP_F;
                        hold_cnt_d = hold_cnt_q;
                    end else begin
                        state_d    = UP_S;
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else if (dn_key) begin
                    state_d = BRAKE;
                end
            end
            DN_S: begin
                if (dn_key) begin
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d    = DN_F;
                        hold_cnt_d = hold_cnt_q;
                    end else begin
                        state_d    = DN_S;
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else if (up_key) begin
                    state_d = BRAKE;
                end
            end
            UP_F: begin
                if (up_key) begin
                    state_d    = UP_F;
                    hold_cnt_d = hold_cnt_q;
                end else if (dn_key) begin
                    state_d = BRAKE;
                end
            end
            DN_F: begin
                if (dn_key) begin
                    state_d    = DN_F;
                    hold_cnt_d = hold_cnt_q;
                end else if (up_key) begin
                    state_d = BRAKE;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = CNT_ZERO;
            end
        endcase

        dir_d  = DIR_STOP;
        fast_d = 1'b0;
        case (state_d)
            UP_S:    dir_d = DIR_UP_S;
            DN_S:    dir_d = DIR_DN_S;
            UP_F: begin
                dir_d  = DIR_UP_F;
                fast_d = 1'b1;
            end
            DN_F: begin
                dir_d  = DIR_DN_F;
                fast_d = 1'b1;
            end
            default: dir_d = DIR_STOP;
        endcase
    end

    // State, hold counter and registered outputs; reset clears everything without waiting for an edge
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= CNT_ZERO;
            dir_q      <= DIR_STOP;
            fast_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dir_q      <= dir_d;
            fast_q     <= fast_d;
        end
    end

    assign dir  = dir_q;
    assign fast = fast_q;

endmodule

// File: tb/tb_pick_dir_ctrl.sv
// tb/tb_pick_dir_ctrl.sv - self-checking bench for pick_dir_ctrl
module tb_pick_dir_ctrl;

    localparam logic [7:0] KU = 8'h1A;
    localparam logic [7:0] KD = 8'h16;
    localparam logic [7:0] KX = 8'h04;
    localparam logic [7:0] K0 = 8'h00;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [2:0] dir;
    logic       fast;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] k0;
        logic [7:0] k1;
        logic [2:0] dir;
        logic       fast;
        string      name;
    } vec_t;

    typedef struct {
        logic [2:0] dir;
        logic       fast;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    pick_dir_ctrl #(
        .KEY_UP   (8'h1A),
        .KEY_DOWN (8'h16),
        .FAST_HOLD(4),
        .CNT_W    (8)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .keycode0 (keycode0),
        .keycode1 (keycode1),
        .dir      (dir),
        .fast     (fast)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] d, input logic f, input string n);
        vec_t v;
        v.k0 = a; v.k1 = b; v.dir = d; v.fast = f; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string n, input logic [2:0] ad, input logic af,
                       input logic [2:0] ed, input logic ef);
        checks++;
        if (ad !== ed || af !== ef) begin
            failures++;
            $display("FAIL %s: got dir=%b fast=%b, expected dir=%b fast=%b", n, ad, af, ed, ef);
        end
    endtask

    // Drive one frame of keys, queue its expectation, compare after the edge
    task automatic step(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] d, input logic f, input string n);
        exp_t e;
        @(negedge frame_clk);
        keycode0 = a;
        keycode1 = b;
        e.dir = d; e.fast = f; e.name = n;
        exp_q.push_back(e);
        @(posedge frame_clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", n);
        end else begin
            e = exp_q.pop_front();
            chk(e.name, dir, fast, e.dir, e.fast);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        keycode0 = K0;
        keycode1 = K0;

        // Up held 7 frames: four slow frames then fast
        for (int i = 0; i < 4; i++) add(KU, K0, 3'b001, 1'b0, "up_hold_slow");
        for (int i = 0; i < 3; i++) add(KU, K0, 3'b100, 1'b1, "up_hold_fast");
        add(K0, K0, 3'b000, 1'b0, "up_release");
        // Down 5 frames then reverse: brake, then slow again from hold_cnt=1
        for (int i = 0; i < 4; i++) add(KD, K0, 3'b010, 1'b0, "dn_hold_slow");
        add(KD, K0, 3'b011, 1'b1, "dn_hold_fast");
        add(KU, K0, 3'b000, 1'b0, "dnf_to_up_brake");
        for (int i = 0; i < 4; i++) add(KU, K0, 3'b001, 1'b0, "after_brake_up_slow");
        add(KU, K0, 3'b100, 1'b1, "after_brake_up_fast");
        // Fast up reversed to down
        add(K0, KD, 3'b000, 1'b0, "upf_to_dn_brake");
        add(K0, KD, 3'b010, 1'b0, "after_brake_dn_slow");
        add(K0, K0, 3'b000, 1'b0, "dn_release");
        // Conflicting keys
        add(KU, KD, 3'b000, 1'b0, "conflict_idle");
        add(KD, K0, 3'b010, 1'b0, "dn_from_idle");
        add(KU, KD, 3'b000, 1'b0, "conflict_in_dns");
        add(KD, K0, 3'b010, 1'b0, "dn_after_conflict");
        add(KD, K0, 3'b010, 1'b0, "dn_second_frame");
        add(K0, K0, 3'b000, 1'b0, "release2");
        // Slow reversal brakes too
        add(KU, K0, 3'b001, 1'b0, "ups_before_rev");
        add(KD, K0, 3'b000, 1'b0, "ups_to_dn_brake");
        add(K0, K0, 3'b000, 1'b0, "brake_to_idle");
        // Single-frame release restarts acceleration
        add(KU, K0, 3'b001, 1'b0, "tap_up1");
        add(KU, K0, 3'b001, 1'b0, "tap_up2");
        add(K0, K0, 3'b000, 1'b0, "tap_gap");
        for (int i = 0; i < 4; i++) add(KU, K0, 3'b001, 1'b0, "tap_restart_slow");
        add(KU, K0, 3'b100, 1'b1, "tap_restart_fast");
        add(K0, K0, 3'b000, 1'b0, "release3");
        // Unrecognised codes are ignored
        add(KX, KD, 3'b010, 1'b0, "unknown_with_dn");
        add(K0, K0, 3'b000, 1'b0, "release4");
        add(KX, K0, 3'b000, 1'b0, "unknown_alone");
        add(K0, KU, 3'b001, 1'b0, "up_in_slot1");
        add(K0, K0, 3'b000, 1'b0, "release5");

        // Reset state
        @(posedge frame_clk);
        #1;
        chk("reset_state", dir, fast, 3'b000, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].k0, vecs[i].k1, vecs[i].dir, vecs[i].fast, vecs[i].name);

        // Asynchronous reset mid-hold while fast
        for (int i = 0; i < 4; i++) step(KU, K0, 3'b001, 1'b0, "pre_reset_slow");
        step(KU, K0, 3'b100, 1'b1, "pre_reset_fast");
        @(negedge frame_clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_immediate", dir, fast, 3'b000, 1'b0);
        @(posedge frame_clk);
        #1;
        chk("reset_held_over_edge", dir, fast, 3'b000, 1'b0);
        @(negedge frame_clk);
        keycode0 = K0;
        Reset    = 1'b0;
        step(K0, K0, 3'b000, 1'b0, "idle_after_reset");
        step(KU, K0, 3'b001, 1'b0, "up_after_reset_slow");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
